// File: rtl/sha512_block_sequencer.sv
// SHA-512 block sequencer: captures a padded message on start and feeds it to
// the compression core one 1024-bit block at a time, MSB block first, waiting
// for core_done between blocks and pulsing done after the last one.
module sha512_block_sequencer #(
  parameter  int unsigned S  = 2048,
  localparam int unsigned NB = S / 1024,
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [S-1:0]  padded_message,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [1023:0] blk_data,
  output logic          blk_first,
  output logic          blk_last,
  output logic [CW-1:0] blk_idx,
  input  logic          core_done,
  output logic          busy,
  output logic          done
);

  localparam int unsigned BW = 1024;

  if ((S == 0) || ((S % BW) != 0)) begin : g_bad_size
    $error("sha512_block_sequencer: S must be a nonzero multiple of 1024");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_idx;
  logic [S-1:0]    r_mbuf;
  logic            r_blk_valid;
  logic [BW-1:0]   r_blk_data;
  logic            r_blk_first;
  logic            r_blk_last;
  logic [CW-1:0]   r_blk_idx;
  logic            r_busy;
  logic            r_done;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_idx_nxt;
  logic [S-1:0]    w_mbuf_nxt;
  logic            w_load;
  logic [BW-1:0]   w_blk_sel;
  logic            w_blk_valid_nxt;
  logic [BW-1:0]   w_blk_data_nxt;
  logic            w_blk_first_nxt;
  logic            w_blk_last_nxt;
  logic [CW-1:0]   w_blk_idx_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // State, buffer and registered outputs; reset clears everything
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_mbuf      <= '0;
      r_blk_valid <= 1'b0;
      r_blk_data  <= '0;
      r_blk_first <= 1'b0;
      r_blk_last  <= 1'b0;
      r_blk_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_mbuf      <= w_mbuf_nxt;
      r_blk_valid <= w_blk_valid_nxt;
      r_blk_data  <= w_blk_data_nxt;
      r_blk_first <= w_blk_first_nxt;
      r_blk_last  <= w_blk_last_nxt;
      r_blk_idx   <= w_blk_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next state, index and buffer; abort overrides every other event
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mbuf_nxt  = r_mbuf;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_mbuf_nxt  = padded_message;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_blk_valid && blk_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          if (r_idx == CW'(NB - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
            w_idx_nxt   = r_idx + CW'(1);
            w_load      = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_mbuf_nxt  = r_mbuf;
      w_load      = 1'b0;
    end
  end

  // Block selected by the upcoming index; block 0 is the MSB slice
  always_comb begin
    w_blk_sel = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (w_idx_nxt == CW'(b)) begin
        w_blk_sel = w_mbuf_nxt[S-1-BW*b -: BW];
      end
    end
  end

  // Next output values; block fields only change when a new block is loaded
  always_comb begin
    w_blk_valid_nxt = (w_state_nxt == S_ISSUE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_blk_data_nxt  = r_blk_data;
    w_blk_first_nxt = r_blk_first;
    w_blk_last_nxt  = r_blk_last;
    w_blk_idx_nxt   = r_blk_idx;
    if (w_load) begin
      w_blk_data_nxt  = w_blk_sel;
      w_blk_first_nxt = (w_idx_nxt == '0);
      w_blk_last_nxt  = (w_idx_nxt == CW'(NB - 1));
      w_blk_idx_nxt   = w_idx_nxt;
    end
  end

  assign blk_valid = r_blk_valid;
  assign blk_data  = r_blk_data;
  assign blk_first = r_blk_first;
  assign blk_last  = r_blk_last;
  assign blk_idx   = r_blk_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/sha512_block_sequencer.md
# sha512_block_sequencer

Controller that sequences a padded SHA-512 message, S bits wide and a multiple of 1024, into the compression core one 1024-bit block at a time. It sits between the message padding stage and the compression core. It captures the padded message on `start` and issues blocks most-significant first over a valid/ready handshake. It waits for the core's completion before issuing the next block, and pulses `done` after the last block.

## Interface
Parameters:
- `S`, default 2048: padded message width; must be a nonzero multiple of 1024, otherwise elaboration fails.
- `NB`, derived as S/1024: number of blocks.
- `CW`, derived as max(1, $clog2(NB)): width of the block index.

Ports:
- `clk`  in  1  clock; all logic is rising-edge triggered.
- `n_rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a message; sampled only in IDLE.
- `abort`  in  1  cancel the current message; synchronous; wins over every other event.
- `padded_message`  in  S  padded message; captured on the cycle `start` is accepted.
- `blk_valid`  out  1  `blk_data` holds a block for the core.
- `blk_ready`  in  1  core accepts the block.
- `blk_data`  out  1024  current block.
- `blk_first`  out  1  current block is block 0; the core loads the IV.
- `blk_last`  out  1  current block is block NB-1.
- `blk_idx`  out  CW  index of the current block.
- `core_done`  in  1  core finished compressing the accepted block.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last block has completed.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Internal registers: message buffer `mbuf[S-1:0]` and index `idx`.
- IDLE:
  - `start`=1 → `mbuf`←`padded_message`, `idx`←0, next state ISSUE.
  - All other inputs are ignored.
- ISSUE:
  - `blk_valid`=1 and `blk_data` = `mbuf[S-1-1024*idx -: 1024]`, so block 0 is the MSB block (it holds the message head).
  - `blk_data`, `blk_first`, `blk_last` and `blk_idx` are held stable while `blk_valid` is high and `blk_ready` is low.
  - Transfer occurs when `blk_valid` & `blk_ready` → next state WAIT.
- WAIT:
  - `blk_valid`=0. `blk_data`, `blk_idx`, `blk_first` and `blk_last` keep the last issued values.
  - `core_done`=1 with `idx`<NB-1 → `idx`++, next state ISSUE.
  - `core_done`=1 with `idx`=NB-1 → next state DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Flag decode: `blk_first` = (`idx`==0); `blk_last` = (`idx`==NB-1). Both are high together when NB=1.
- `abort`=1 in any state → next state IDLE, `idx`←0, `blk_valid`←0, and no `done` pulse. `mbuf` is retained.
- Events ignored outside the states above:
  - `start` outside IDLE.
  - `core_done` in IDLE, ISSUE or DONE, including a `core_done` coinciding with the transfer cycle.
  - `blk_ready` outside ISSUE.
- Reset (`n_rst`=1 at any time, mid-message included) forces IDLE immediately. The following all clear to 0: `idx`, `mbuf`, `blk_valid`, `blk_data`, `blk_first`, `blk_last`, `blk_idx`, `busy`, `done`.
  - `blk_first` is 0 during reset even though `idx`=0; the flag outputs are registered or gated by state.
- All outputs are registered or decoded from registered state only. There are no combinational paths from input to output.

## Timing
- `start` sampled at edge t → ISSUE from t+1: `blk_valid`=1, `busy`=1, block 0 on `blk_data`.
- With `blk_ready`=1, transfer happens at the first ISSUE edge and WAIT starts one cycle later. The minimum cost is 1 cycle per block issue.
- `core_done` sampled at edge c in WAIT:
  - Not the last block → ISSUE of the next block from c+1.
  - Last block → `done`=1 during cycle c+1, IDLE with `busy`=0 from c+2.
- A new `start` is accepted in the first IDLE cycle after DONE.
- Minimum latency from `start` to `done`, with `blk_ready` tied high and `core_done` returned 1 cycle after each transfer: 3*NB+1 cycles.
- The core must assert `core_done` no earlier than the cycle after the transfer.

## Test plan
- S=2048, `blk_ready`=1, `core_done` 1 cycle after each transfer, `padded_message`={1024'hA.., 1024'h5..}:
  - Blocks are issued in order A.. then 5.. with `blk_idx` 0 then 1.
  - `blk_first` is high only on A..; `blk_last` is high only on 5...
  - `done` pulses at cycle 7 after `start`; `busy` falls the next cycle.
- Backpressure: `blk_ready` held low for 5 cycles in ISSUE → `blk_data`/`blk_idx` stable and `blk_valid` high throughout; the transfer happens on the first `blk_ready`=1.
- Spurious inputs:
  - `start` in ISSUE and WAIT has no effect.
  - `core_done` in ISSUE has no effect; `idx` unchanged.
  - `padded_message` changed after capture → issued data still equals the captured value.
- `abort` in WAIT after block 0 → IDLE next cycle, `busy`=0, no `done`. A following `start` reissues from block 0 with `blk_first`=1.
- `n_rst` pulsed mid-WAIT → all outputs 0 immediately. After release, the block stays idle until `start`.
- NB=1 (S=1024):
  - `blk_first`=`blk_last`=1 on the single block.
  - `done` pulses 4 cycles after `start`, with `core_done` returned 1 cycle after transfer.
